// File: rtl/scrypt_block_mix.sv
// scrypt BlockMix_salsa20/8 (r=1) sequencer that drives an external salsa20/8 core.
// Optional watchdog per salsa call: define SCRYPT_BLOCKMIX_TIMEOUT_EN (adds TIMEOUT_CYCLES and error).
module scrypt_block_mix
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mix_v,
  input  logic [1023:0] b_in,
  input  logic [1023:0] v_in,
  output logic          busy,
  output logic          done,
  output logic [1023:0] b_out,
  output logic          salsa_init,
  output logic [511:0]  salsa_x,
  input  logic [511:0]  salsa_out,
  input  logic          salsa_valid
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
  ,
  output logic          error
`endif
);

  localparam int unsigned HW = 512;
  localparam int unsigned BW = 2 * HW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [HW-1:0] b0, b0_n, b1, b1_n, y0, y0_n, x_n;
  logic [BW-1:0] blk, bout_n;
  logic          armed, armed_n;
  logic          init_n, done_n, busy_n;

`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n;
`endif

  assign blk = mix_v ? (b_in ^ v_in) : b_in;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_n = state;
    b0_n    = b0;
    b1_n    = b1;
    y0_n    = y0;
    x_n     = salsa_x;
    bout_n  = b_out;
    armed_n = armed;
    init_n  = 1'b0;
    done_n  = 1'b0;
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          b0_n    = blk[HW-1:0];
          b1_n    = blk[BW-1:HW];
          x_n     = blk[HW-1:0] ^ blk[BW-1:HW];
          init_n  = 1'b1;
          state_n = ISSUE0;
        end
      end
      ISSUE0, ISSUE1: begin
        // armed stays low for the first WAIT cycle: the core may still show a stale valid.
        armed_n = 1'b0;
        state_n = (state == ISSUE0) ? WAIT0 : WAIT1;
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      WAIT0, WAIT1: begin
        armed_n = 1'b1;
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
        cnt_n   = cnt + CW'(1);
`endif
        if (armed && salsa_valid) begin
          if (state == WAIT0) begin
            y0_n    = salsa_out;
            x_n     = salsa_out ^ b1;
            init_n  = 1'b1;
            state_n = ISSUE1;
          end else begin
            bout_n  = {salsa_out, y0};
            done_n  = 1'b1;
            state_n = FINISH;
          end
        end
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      b0         <= '0;
      b1         <= '0;
      y0         <= '0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      salsa_init <= 1'b0;
      salsa_x    <= '0;
      b_out      <= '0;
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
      cnt        <= '0;
      error      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      b0         <= b0_n;
      b1         <= b1_n;
      y0         <= y0_n;
      armed      <= armed_n;
      busy       <= busy_n;
      done       <= done_n;
      salsa_init <= init_n;
      salsa_x    <= x_n;
      b_out      <= bout_n;
`ifdef SCRYPT_BLOCKMIX_TIMEOUT_EN
      cnt        <= cnt_n;
      error      <= err_n;
`endif
    end
  end

endmodule
